qif_neuron_array: RTL

Time-multiplexed array of quadratic integrate-and-fire (QIF) neurons. It is the parametrised successor to the single-neuron QIF core that sits behind the chip's top-level pin wrapper. One shared update datapath sweeps `N_CH` channels round-robin, each with its own bias, membrane potential and refractory counter. It adds a selectable leaky-integrate (LIF) mode, a programmable refractory period, and per-channel spike reporting.

---
 rtl/qif_neuron_array.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/qif_neuron_array.sv
// Time-multiplexed quadratic / leaky integrate-and-fire neuron array.
// One shared update datapath sweeps the channels round-robin; each channel keeps its own V, bias and refractory count.

module qif_ch #(
  parameter int W       = 8,
  parameter int RW      = 2,
  parameter int V_RESET = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          upd,
  input  logic [W-1:0]  v_nxt,
  input  logic [RW-1:0] r_nxt,
  input  logic          b_we,
  input  logic [W-1:0]  b_data,
  output logic [W-1:0]  v,
  output logic [RW-1:0] r,
  output logic [W-1:0]  b
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= W'(V_RESET);
      r <= '0;
      b <= '0;
    end else begin
      if (upd) begin
        v <= v_nxt;
        r <= r_nxt;
      end
      // a same-cycle write lands after the update has already read b
      if (b_we) b <= b_data;
    end
  end
endmodule

module qif_update #(
  parameter int W       = 8,
  parameter int RW      = 2,
  parameter int SHIFT   = 4,
  parameter int V_PEAK  = 200,
  parameter int V_RESET = 16,
  parameter int REFRAC  = 2
) (
  input  logic [W-1:0]  v,
  input  logic [W-1:0]  b,
  input  logic [RW-1:0] r,
  input  logic          mode,
  output logic [W-1:0]  v_nxt,
  output logic [RW-1:0] r_nxt,
  output logic          fire
);
  localparam logic [2*W:0] PEAK = (2*W+1)'(V_PEAK);

  logic [2*W-1:0] vv;
  logic [2*W:0]   s_q, s;
  logic [W:0]     s_l;

  // QIF sum is sized 2W+1 so the quadratic term can never wrap
  assign vv  = {{W{1'b0}}, v} * {{W{1'b0}}, v};
  assign s_q = {1'b0, vv >> SHIFT} + {{(W+1){1'b0}}, v} + {{(W+1){1'b0}}, b};
  assign s_l = {1'b0, v} - {1'b0, v >> SHIFT} + {1'b0, b};
  assign s   = mode ? {{W{1'b0}}, s_l} : s_q;

  always_comb begin
    fire  = 1'b0;
    v_nxt = s[W-1:0];
    r_nxt = r;
    if (r != '0) begin
      v_nxt = W'(V_RESET);
      r_nxt = r - RW'(1);
    end else if (s >= PEAK) begin
      fire  = 1'b1;
      v_nxt = W'(V_RESET);
      r_nxt = RW'(REFRAC);
    end
  end
endmodule

module qif_neuron_array #(
  parameter int N_CH    = 4,
  parameter int W       = 8,
  parameter int SHIFT   = 4,
  parameter int V_PEAK  = 200,
  parameter int V_RESET = 16,
  parameter int REFRAC  = 2,
  localparam int CW     = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic            b_wr,
  input  logic [CW-1:0]   b_ch,
  input  logic [W-1:0]    b_data,
  output logic [W-1:0]    v_out,
  output logic [CW-1:0]   v_ch,
  output logic            v_valid,
  output logic            spike,
  output logic [N_CH-1:0] spike_vec,
  output logic            sweep_done
);
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [N_CH-1:0][W-1:0]  v_arr, b_arr;
  logic [N_CH-1:0][RW-1:0] r_arr;
  logic [CW-1:0]           idx;
  logic [W-1:0]            v_nxt;
  logic [RW-1:0]           r_nxt;
  logic                    fire;

  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_ch
      qif_ch #(.W(W), .RW(RW), .V_RESET(V_RESET)) u_ch (
        .clk    (clk),
        .rst    (rst),
        .upd    (en && (idx == CW'(i))),
        .v_nxt  (v_nxt),
        .r_nxt  (r_nxt),
        .b_we   (b_wr && (b_ch == CW'(i))),
        .b_data (b_data),
        .v      (v_arr[i]),
        .r      (r_arr[i]),
        .b      (b_arr[i])
      );
    end
  endgenerate

  qif_update #(
    .W(W), .RW(RW), .SHIFT(SHIFT), .V_PEAK(V_PEAK), .V_RESET(V_RESET), .REFRAC(REFRAC)
  ) u_upd (
    .v     (v_arr[idx]),
    .b     (b_arr[idx]),
    .r     (r_arr[idx]),
    .mode  (mode),
    .v_nxt (v_nxt),
    .r_nxt (r_nxt),
    .fire  (fire)
  );

  // N_CH is a power of two, so the index wraps by plain overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      v_out      <= '0;
      v_ch       <= '0;
      v_valid    <= 1'b0;
      spike      <= 1'b0;
      spike_vec  <= '0;
      sweep_done <= 1'b0;
    end else begin
      v_valid    <= en;
      spike      <= en && fire;
      sweep_done <= en && (idx == CW'(N_CH - 1));
      if (en) begin
        idx            <= idx + CW'(1);
        v_out          <= v_nxt;
        v_ch           <= idx;
        spike_vec[idx] <= fire;
      end
    end
  end
endmodule
